aha_clock_select_ctrl: RTL and testbench



---
 rtl/aha_clock_select_ctrl.sv | 154 +++++++++++++++
 tb/tb_aha_clock_select_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aha_clock_select_ctrl.sv
// Sequencer for the two-source glitch-free clock switch. Arbitrates HW/SW
// switch requests (HW has priority), drives SELECT, waits for both slice
// acknowledges through synchronizers, settles, then commits CUR_SEL.
// Stalled switches time out and fall back to the committed source.
module aha_clock_select_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic HW_REQ_VALID,
  input  logic HW_REQ_SEL,
  output logic HW_REQ_READY,
  input  logic SW_REQ_VALID,
  input  logic SW_REQ_SEL,
  output logic SW_REQ_READY,
  input  logic SRC1_READY,
  input  logic ACK0,
  input  logic ACK1,
  output logic SELECT,
  output logic CUR_SEL,
  output logic BUSY,
  output logic DONE,
  output logic ERR_REFUSED,
  output logic ERR_TIMEOUT
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, SETTLE, RECOVER} state_t;

  state_t          state, state_n;
  logic            tgt, tgt_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            select_n, cur_sel_n, done_n, err_ref_n, err_to_n;

  logic [SYNC_STAGES-1:0] rdy_ff, a0_ff, a1_ff;
  logic s_rdy, s_a0, s_a1;

  // Synchronizer chains for the asynchronous PLL-lock and slice acks
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      rdy_ff <= '0;
      a0_ff  <= '0;
      a1_ff  <= '0;
    end else begin
      rdy_ff <= {rdy_ff[SYNC_STAGES-2:0], SRC1_READY};
      a0_ff  <= {a0_ff[SYNC_STAGES-2:0], ACK0};
      a1_ff  <= {a1_ff[SYNC_STAGES-2:0], ACK1};
    end
  end

  assign s_rdy = rdy_ff[SYNC_STAGES-1];
  assign s_a0  = a0_ff[SYNC_STAGES-1];
  assign s_a1  = a1_ff[SYNC_STAGES-1];

  // Both slices agree: requested source on, the other off
  function automatic logic ack_ok(input logic x, input logic a0, input logic a1);
    return x ? (a1 & ~a0) : (a0 & ~a1);
  endfunction

  logic req_any, req_sel;
  assign req_any      = HW_REQ_VALID | SW_REQ_VALID;
  assign req_sel      = HW_REQ_VALID ? HW_REQ_SEL : SW_REQ_SEL;
  assign HW_REQ_READY = (state == IDLE) & HW_REQ_VALID;
  assign SW_REQ_READY = (state == IDLE) & SW_REQ_VALID & ~HW_REQ_VALID;
  assign BUSY         = (state != IDLE);

  // Next-state, counter and response-pulse logic
  always_comb begin
    state_n   = state;
    select_n  = SELECT;
    cur_sel_n = CUR_SEL;
    tgt_n     = tgt;
    cnt_n     = cnt;
    done_n    = 1'b0;
    err_ref_n = 1'b0;
    err_to_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          if (req_sel == CUR_SEL) begin
            done_n = 1'b1;
          end else if (req_sel && !s_rdy) begin
            err_ref_n = 1'b1;
          end else begin
            select_n = req_sel;
            tgt_n    = req_sel;
            cnt_n    = '0;
            state_n  = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (ack_ok(tgt, s_a0, s_a1)) begin
          cnt_n   = '0;
          state_n = SETTLE;
        end else if (cnt == TO_LAST) begin
          err_to_n = 1'b1;
          select_n = CUR_SEL;
          cnt_n    = '0;
          state_n  = RECOVER;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SETTLE: begin
        if (cnt == SET_LAST) begin
          cur_sel_n = tgt;
          done_n    = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RECOVER: begin
        if (ack_ok(CUR_SEL, s_a0, s_a1)) begin
          state_n = IDLE;
        end else if (cnt == TO_LAST) begin
          err_to_n = 1'b1;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state       <= IDLE;
      SELECT      <= 1'b0;
      CUR_SEL     <= 1'b0;
      tgt         <= 1'b0;
      cnt         <= '0;
      DONE        <= 1'b0;
      ERR_REFUSED <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      state       <= state_n;
      SELECT      <= select_n;
      CUR_SEL     <= cur_sel_n;
      tgt         <= tgt_n;
      cnt         <= cnt_n;
      DONE        <= done_n;
      ERR_REFUSED <= err_ref_n;
      ERR_TIMEOUT <= err_to_n;
    end
  end
endmodule

// File: tb/tb_aha_clock_select_ctrl.sv
// Bench for aha_clock_select_ctrl: directed scenarios with hand-derived
// cycle counts, then randomized traffic against a deadline-based model.
module tb_aha_clock_select_ctrl;
  localparam int SS = 2;
  localparam int TO = 8;
  localparam int ST = 4;
  localparam int MI = 0, MW = 1, MS = 2, MR = 3;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic HW_REQ_VALID = 0, HW_REQ_SEL = 0, SW_REQ_VALID = 0, SW_REQ_SEL = 0;
  logic SRC1_READY = 0, ACK0 = 0, ACK1 = 0;
  logic HW_REQ_READY, SW_REQ_READY, SELECT, CUR_SEL, BUSY, DONE, ERR_REFUSED, ERR_TIMEOUT;

  aha_clock_select_ctrl #(.SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .HW_REQ_VALID(HW_REQ_VALID), .HW_REQ_SEL(HW_REQ_SEL), .HW_REQ_READY(HW_REQ_READY),
    .SW_REQ_VALID(SW_REQ_VALID), .SW_REQ_SEL(SW_REQ_SEL), .SW_REQ_READY(SW_REQ_READY),
    .SRC1_READY(SRC1_READY), .ACK0(ACK0), .ACK1(ACK1),
    .SELECT(SELECT), .CUR_SEL(CUR_SEL), .BUSY(BUSY), .DONE(DONE),
    .ERR_REFUSED(ERR_REFUSED), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  bit started = 0;

  // model state: mode, absolute deadline cycle, delay lines for synchronizers
  int m_mode = MI, m_cyc = 0, m_dl = 0;
  bit m_sel = 0, m_cur = 0, m_tgt = 0, m_done = 0, m_ref = 0, m_to = 0;
  bit rdy_l[SS], a0_l[SS], a1_l[SS];

  // environment: switch acks follow SELECT three cycles late unless stalled
  int env_mode = 0;
  bit sel_h[3];

  logic o_sel, o_cur, o_busy, o_done, o_ref, o_to, o_hwr, o_swr;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit shows(input bit x, input bit a0, input bit a1);
    return x ? (a1 && !a0) : (a0 && !a1);
  endfunction

  task automatic model_step();
    bit srdy, sa0, sa1, s;
    srdy = rdy_l[SS-1]; sa0 = a0_l[SS-1]; sa1 = a1_l[SS-1];
    m_done = 0; m_ref = 0; m_to = 0;
    if (!RESETn) begin
      m_mode = MI; m_sel = 0; m_cur = 0; m_tgt = 0;
      for (int i = 0; i < SS; i++) begin rdy_l[i] = 0; a0_l[i] = 0; a1_l[i] = 0; end
    end else begin
      case (m_mode)
        MI: if (HW_REQ_VALID || SW_REQ_VALID) begin
              s = HW_REQ_VALID ? HW_REQ_SEL : SW_REQ_SEL;
              if (s == m_cur) m_done = 1;
              else if (s && !srdy) m_ref = 1;
              else begin m_sel = s; m_tgt = s; m_mode = MW; m_dl = m_cyc + TO; end
            end
        MW: if (shows(m_tgt, sa0, sa1)) begin m_mode = MS; m_dl = m_cyc + ST; end
            else if (m_cyc == m_dl) begin m_to = 1; m_sel = m_cur; m_mode = MR; m_dl = m_cyc + TO; end
        MS: if (m_cyc == m_dl) begin m_cur = m_tgt; m_done = 1; m_mode = MI; end
        default: if (shows(m_cur, sa0, sa1)) m_mode = MI;
                 else if (m_cyc == m_dl) begin m_to = 1; m_dl = m_dl + TO; end
      endcase
      for (int i = SS - 1; i > 0; i--) begin
        rdy_l[i] = rdy_l[i-1]; a0_l[i] = a0_l[i-1]; a1_l[i] = a1_l[i-1];
      end
      rdy_l[0] = SRC1_READY; a0_l[0] = ACK0; a1_l[0] = ACK1;
    end
    m_cyc++;
  endtask

  // compare the current cycle, then advance through the next clock edge
  task automatic tick();
    @(negedge CLK);
    o_sel = SELECT; o_cur = CUR_SEL; o_busy = BUSY; o_done = DONE;
    o_ref = ERR_REFUSED; o_to = ERR_TIMEOUT; o_hwr = HW_REQ_READY; o_swr = SW_REQ_READY;
    if (started) begin
      chk("select", o_sel, m_sel);
      chk("cur_sel", o_cur, m_cur);
      chk("busy", o_busy, m_mode != MI);
      chk("done", o_done, m_done);
      chk("err_refused", o_ref, m_ref);
      chk("err_timeout", o_to, m_to);
      chk("hw_ready", o_hwr, (m_mode == MI) && HW_REQ_VALID);
      chk("sw_ready", o_swr, (m_mode == MI) && SW_REQ_VALID && !HW_REQ_VALID);
    end
    @(posedge CLK);
    model_step();
    #1;
    case (env_mode)
      0: begin ACK1 = sel_h[2]; ACK0 = !sel_h[2]; end
      2: begin ACK0 = 1; ACK1 = 0; end
      3: begin ACK0 = 0; ACK1 = 0; end
      default: ;
    endcase
    sel_h[2] = sel_h[1]; sel_h[1] = sel_h[0]; sel_h[0] = SELECT;
  endtask

  task automatic idle(input int n);
    HW_REQ_VALID = 0; SW_REQ_VALID = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int n;

  initial begin
    RESETn = 0;
    idle(2);
    started = 1;
    tick();
    chk("reset_select", o_sel, 0);
    chk("reset_busy", o_busy, 0);
    RESETn = 1;
    SRC1_READY = 1;
    idle(6);

    // SW switch to source 1: DONE lands 11 cycles after accept
    SW_REQ_VALID = 1; SW_REQ_SEL = 1;
    tick();
    chk("t1_sw_ready", o_swr, 1);
    SW_REQ_VALID = 0;
    tick(); n = 1;
    chk("t1_select", o_sel, 1);
    chk("t1_busy", o_busy, 1);
    while (!o_done && n < 40) begin tick(); n++; end
    chk("t1_done_latency", n, 11);
    chk("t1_cur_sel", o_cur, 1);

    // HW and SW together: HW wins; SW accepted in the DONE cycle
    HW_REQ_VALID = 1; HW_REQ_SEL = 0; SW_REQ_VALID = 1; SW_REQ_SEL = 0;
    tick();
    chk("t2_hw_ready", o_hwr, 1);
    chk("t2_sw_ready", o_swr, 0);
    HW_REQ_VALID = 0;
    n = 0;
    while (!o_done && n < 40) begin tick(); n++; end
    chk("t2_sw_ready_at_done", o_swr, 1);
    chk("t2_cur_sel", o_cur, 0);
    SW_REQ_VALID = 0;
    tick();
    chk("t2_noop_done", o_done, 1);
    chk("t2_noop_busy", o_busy, 0);

    // refused: source 1 not ready
    SRC1_READY = 0;
    idle(4);
    HW_REQ_VALID = 1; HW_REQ_SEL = 1;
    tick();
    HW_REQ_VALID = 0;
    tick();
    chk("t3_err_refused", o_ref, 1);
    chk("t3_select", o_sel, 0);
    chk("t3_busy", o_busy, 0);

    // no-op request for the committed source
    SW_REQ_VALID = 1; SW_REQ_SEL = 0;
    tick();
    SW_REQ_VALID = 0;
    tick();
    chk("t4_done", o_done, 1);
    chk("t4_select", o_sel, 0);
    chk("t4_busy", o_busy, 0);

    // timeout: slice 1 never acknowledges
    SRC1_READY = 1; env_mode = 2;
    idle(4);
    HW_REQ_VALID = 1; HW_REQ_SEL = 1;
    tick();
    HW_REQ_VALID = 0;
    tick(); n = 1;
    while (!o_to && n < 40) begin tick(); n++; end
    chk("t5_timeout_cycle", n, 9);
    chk("t5_select_back", o_sel, 0);
    n = 0;
    while (o_busy && n < 10) begin tick(); n++; end
    chk("t5_recover_bound", n <= SS + 2, 1);
    chk("t5_no_done", o_done, 0);
    chk("t5_cur_sel", o_cur, 0);

    // reset in the middle of SETTLE
    env_mode = 0;
    idle(6);
    SW_REQ_VALID = 1; SW_REQ_SEL = 1;
    tick();
    SW_REQ_VALID = 0;
    tick(); n = 1;
    while (n < 7) begin tick(); n++; end
    chk("t6_in_settle", o_busy && o_sel, 1);
    RESETn = 0;
    tick();
    RESETn = 1;
    tick();
    chk("t6_select", o_sel, 0);
    chk("t6_cur_sel", o_cur, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_done", o_done, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(199) == 0) begin
        RESETn = 0; HW_REQ_VALID = 0; SW_REQ_VALID = 0;
      end else begin
        RESETn = 1;
        HW_REQ_VALID = ($urandom_range(5) == 0);
        SW_REQ_VALID = ($urandom_range(5) == 0);
        HW_REQ_SEL = 1'($urandom_range(1));
        SW_REQ_SEL = 1'($urandom_range(1));
      end
      if ($urandom_range(39) == 0) SRC1_READY = !SRC1_READY;
      if ($urandom_range(59) == 0) env_mode = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
      tick();
    end
    RESETn = 1;
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
